control_word_sequencer: RTL

CONTROL_WORD_SEQUENCER -- requirements
Module: control_word_sequencer

---
 rtl/control_word_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/control_word_sequencer.sv
// Control-word sequencer: a small program store that streams words to a datapath
// with a ready handshake, supporting single-pass, looping and single-step modes.
module control_word_sequencer #(
  parameter int unsigned CW_WIDTH = 21,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [CW_WIDTH-1:0] wr_data,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [AW-1:0]       last_addr,
  input  logic                step,
  input  logic                dp_ready,
  input  logic                abort,
  output logic [CW_WIDTH-1:0] control_word,
  output logic                cw_valid,
  output logic [AW-1:0]       pc,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {StIdle, StRun, StWaitStep, StDone} state_e;

  localparam logic [AW:0] DepthW   = DEPTH[AW:0];
  localparam logic [AW:0] MaxAddrW = DepthW - 1'b1;

  logic [CW_WIDTH-1:0] mem [DEPTH];

  state_e              state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d;
  logic [CW_WIDTH-1:0] cw_q, cw_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                loop_q, loop_d;
  logic                stepm_q, stepm_d;
  logic [AW-1:0]       last_q, last_d;

  logic                wr_ok;
  logic [CW_WIDTH-1:0] first_word;
  logic [AW-1:0]       pc_next;
  logic [AW-1:0]       last_clamped;

  assign wr_ok   = wr_en && !busy_q && ({1'b0, wr_addr} < DepthW);
  assign pc_next = pc_q + 1'b1;

  // A write to address 0 alongside start must be seen by the first fetch.
  assign first_word = (wr_ok && (wr_addr == '0)) ? wr_data : mem[0];

  assign last_clamped = ({1'b0, last_addr} > MaxAddrW) ? MaxAddrW[AW-1:0] : last_addr;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cw_d    = cw_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    loop_d  = loop_q;
    stepm_d = stepm_q;
    last_d  = last_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          loop_d  = (mode == 2'b01);
          stepm_d = (mode == 2'b10);
          last_d  = last_clamped;
          state_d = StRun;
          pc_d    = '0;
          cw_d    = first_word;
          valid_d = 1'b1;
        end
      end
      StRun: begin
        if (valid_q && dp_ready) begin
          if (pc_q != last_q) begin
            if (stepm_q) begin
              state_d = StWaitStep;
              valid_d = 1'b0;
              cw_d    = '0;
            end else begin
              pc_d = pc_next;
              cw_d = mem[pc_next];
            end
          end else if (loop_q) begin
            pc_d = '0;
            cw_d = mem[0];
          end else begin
            state_d = StDone;
            valid_d = 1'b0;
            cw_d    = '0;
            done_d  = 1'b1;
          end
        end
      end
      StWaitStep: begin
        if (step) begin
          state_d = StRun;
          pc_d    = pc_next;
          cw_d    = mem[pc_next];
          valid_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase

    if (abort) begin
      state_d = StIdle;
      pc_d    = '0;
      cw_d    = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cw_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      loop_q  <= 1'b0;
      stepm_q <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cw_q    <= cw_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      loop_q  <= loop_d;
      stepm_q <= stepm_d;
      last_q  <= last_d;
    end
  end

  assign control_word = cw_q;
  assign cw_valid     = valid_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
